// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the 6-bit opcode enumeration.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [5:0] {
    OpAdd    = 6'd0,
    OpSub    = 6'd1,
    OpSll    = 6'd2,
    OpSlt    = 6'd3,
    OpSltu   = 6'd4,
    OpXor    = 6'd5,
    OpSrl    = 6'd6,
    OpSra    = 6'd7,
    OpOr     = 6'd8,
    OpAnd    = 6'd9,
    OpSlli   = 6'd10,
    OpSrli   = 6'd11,
    OpSrai   = 6'd12,
    OpPassB  = 6'd13,
    OpPassA  = 6'd14,
    OpEq     = 6'd15,
    OpNe     = 6'd16,
    OpLt     = 6'd17,
    OpGe     = 6'd18,
    OpLtu    = 6'd19,
    OpGeu    = 6'd20,
    OpMul    = 6'd21,
    OpMulh   = 6'd22,
    OpMulhsu = 6'd23,
    OpMulhu  = 6'd24,
    OpDiv    = 6'd25,
    OpDivu   = 6'd26,
    OpRem    = 6'd27,
    OpRemu   = 6'd28
  } alu_op_e;

endpackage

// File: rtl/alu_div.sv
// Single-cycle combinational divide/remainder with divide-by-zero and overflow handling.
module alu_div
  import alu_pkg::*;
#(
  parameter int unsigned Width = XLEN
) (
  input  alu_op_e            op_i,
  input  logic [Width-1:0]   a_i,
  input  logic [Width-1:0]   b_i,
  output logic [Width-1:0]   result_o
);

  logic             is_signed;
  logic             neg_a;
  logic             neg_b;
  logic             div_zero;
  logic [Width-1:0] abs_a;
  logic [Width-1:0] abs_b;
  logic [Width-1:0] divisor;
  logic [Width-1:0] quo;
  logic [Width-1:0] rem;
  logic [Width-1:0] quo_s;
  logic [Width-1:0] rem_s;

  // Divide magnitudes unsigned, then restore signs. The overflow case
  // (most-negative / -1) needs no special path: |A| = 2^(W-1), |B| = 1, both
  // negative, so the quotient is 2^(W-1) unsigned and the remainder is zero.
  always_comb begin
    is_signed = (op_i == OpDiv) || (op_i == OpRem);
    neg_a     = is_signed & a_i[Width-1];
    neg_b     = is_signed & b_i[Width-1];
    abs_a     = neg_a ? (~a_i + 1'b1) : a_i;
    abs_b     = neg_b ? (~b_i + 1'b1) : b_i;
    div_zero  = (b_i == '0);
    // Keep the divider well-defined on zero; the result is overridden below.
    divisor   = div_zero ? Width'(1) : abs_b;
    quo       = abs_a / divisor;
    rem       = abs_a % divisor;
    quo_s     = (neg_a ^ neg_b) ? (~quo + 1'b1) : quo;
    rem_s     = neg_a ? (~rem + 1'b1) : rem;
  end

  // Select quotient or remainder, applying the divide-by-zero results.
  always_comb begin
    result_o = '0;
    case (op_i)
      OpDiv, OpDivu: result_o = div_zero ? '1 : quo_s;
      OpRem, OpRemu: result_o = div_zero ? a_i : rem_s;
      default:       result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// Single-cycle RV32IM-style ALU with a registered result (latency 1).
module alu_core #(
  parameter int unsigned XLEN = alu_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [5:0]      ALUop_i,
  input  logic [XLEN-1:0] operand_A,
  input  logic [XLEN-1:0] operand_B,
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] result_o
);

  import alu_pkg::*;

  localparam int unsigned ShW = $clog2(XLEN);

  alu_op_e             op;
  logic [ShW-1:0]      sh_b;
  logic [2*XLEN-1:0]   mul_a;
  logic [2*XLEN-1:0]   mul_b;
  logic [2*XLEN-1:0]   product;
  logic [XLEN-1:0]     div_result;
  logic [XLEN-1:0]     result_d;

  assign op   = alu_op_e'(ALUop_i);
  assign sh_b = operand_B[ShW-1:0];

  // One shared multiplier: operands are sign- or zero-extended to 2*XLEN so the
  // wrapped product's high half is correct for every MULH variant.
  assign mul_a = ((op == OpMulh) || (op == OpMulhsu)) ?
                 {{XLEN{operand_A[XLEN-1]}}, operand_A} : {{XLEN{1'b0}}, operand_A};
  assign mul_b = (op == OpMulh) ?
                 {{XLEN{operand_B[XLEN-1]}}, operand_B} : {{XLEN{1'b0}}, operand_B};
  assign product = mul_a * mul_b;

  alu_div #(
    .Width (XLEN)
  ) u_alu_div (
    .op_i     (op),
    .a_i      (operand_A),
    .b_i      (operand_B),
    .result_o (div_result)
  );

  // Next result, decoded from the opcode; unused opcodes yield zero.
  always_comb begin
    result_d = '0;
    case (op)
      OpAdd:    result_d = operand_A + operand_B;
      OpSub:    result_d = operand_A - operand_B;
      OpSll:    result_d = operand_A << sh_b;
      OpSlt:    result_d = XLEN'($signed(operand_A) < $signed(operand_B));
      OpSltu:   result_d = XLEN'(operand_A < operand_B);
      OpXor:    result_d = operand_A ^ operand_B;
      OpSrl:    result_d = operand_A >> sh_b;
      OpSra:    result_d = $signed(operand_A) >>> sh_b;
      OpOr:     result_d = operand_A | operand_B;
      OpAnd:    result_d = operand_A & operand_B;
      OpSlli:   result_d = operand_A << shamt;
      OpSrli:   result_d = operand_A >> shamt;
      OpSrai:   result_d = $signed(operand_A) >>> shamt;
      OpPassB:  result_d = operand_B;
      OpPassA:  result_d = operand_A;
      OpEq:     result_d = XLEN'(operand_A == operand_B);
      OpNe:     result_d = XLEN'(operand_A != operand_B);
      OpLt:     result_d = XLEN'($signed(operand_A) < $signed(operand_B));
      OpGe:     result_d = XLEN'($signed(operand_A) >= $signed(operand_B));
      OpLtu:    result_d = XLEN'(operand_A < operand_B);
      OpGeu:    result_d = XLEN'(operand_A >= operand_B);
      OpMul:    result_d = product[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: result_d = product[2*XLEN-1:XLEN];
      OpDiv, OpDivu, OpRem, OpRemu: result_d = div_result;
      default:  result_d = '0;
    endcase
  end

  // Output register; reset clears it immediately and drops any pending value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_o <= '0;
    end else begin
      result_o <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed corner cases plus randomized ops
// compared against a 64-bit arithmetic reference model.
module tb_alu_core;

  logic        clk_i;
  logic        rst_ni;
  logic [5:0]  ALUop_i;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic [4:0]  shamt;
  logic [31:0] result_o;

  int n_checks;
  int n_errors;

  alu_core #(
    .XLEN (32)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .ALUop_i   (ALUop_i),
    .operand_A (operand_A),
    .operand_B (operand_B),
    .shamt     (shamt),
    .result_o  (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model computed with wide signed/unsigned integer arithmetic.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    int              n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    n  = int'(b[4:0]);
    case (op)
      0:  return 32'(ua + ub);
      1:  return 32'(ua - ub);
      2:  return 32'(ua << n);
      3:  return (sa < sb) ? 32'd1 : 32'd0;
      4:  return (ua < ub) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return 32'(ua >> n);
      7:  return 32'(sa >>> n);
      8:  return a | b;
      9:  return a & b;
      10: return 32'(ua << sh);
      11: return 32'(ua >> sh);
      12: return 32'(sa >>> sh);
      13: return b;
      14: return a;
      15: return (a == b) ? 32'd1 : 32'd0;
      16: return (a != b) ? 32'd1 : 32'd0;
      17: return (sa < sb) ? 32'd1 : 32'd0;
      18: return (sa >= sb) ? 32'd1 : 32'd0;
      19: return (ua < ub) ? 32'd1 : 32'd0;
      20: return (ua >= ub) ? 32'd1 : 32'd0;
      21: return 32'(sa * sb);
      22: return 32'((sa * sb) >>> 32);
      23: return 32'((sa * longint'(ub)) >>> 32);
      24: return 32'((ua * ub) >> 32);
      25: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      26: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      27: return (b == 0) ? a : 32'(sa % sb);
      28: return (b == 0) ? a : 32'(ua % ub);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0;
    corners[1] = 32'h1;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    ALUop_i   = 6'(op);
    operand_A = a;
    operand_B = b;
    shamt     = sh;
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic run_exp(input string tag, input int op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
    @(negedge clk_i);
    drive(op, a, b, sh);
    @(posedge clk_i);
    #1;
    check_eq(tag, result_o, exp);
  endtask

  initial begin
    logic [31:0] exp_q [$];
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    n_checks = 0;
    n_errors = 0;
    rst_ni   = 1'b0;
    drive(0, 32'h0, 32'h0, 5'd0);

    // Held in reset with random inputs: output stays zero across edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      drive(int'($urandom_range(0, 28)), $urandom(), $urandom(), 5'($urandom()));
      @(posedge clk_i);
      #1;
      check_eq("reset_hold", result_o, 32'h0);
    end

    // First edge after release registers the current inputs.
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 32'd5, 32'd7, 5'd0);
    @(posedge clk_i);
    #1;
    check_eq("add_5_7", result_o, 32'd12);

    run_exp("sub_wrap",   1,  32'h0,         32'h1,         5'd0,  32'hFFFF_FFFF);
    run_exp("slt_neg",    3,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1);
    run_exp("sltu_big",   4,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0);
    run_exp("sra_lowb",   7,  32'h8000_0000, 32'h0000_0024, 5'd0,  32'hF800_0000);
    run_exp("srli_31",    11, 32'h8000_0000, 32'h0,         5'd31, 32'h1);
    run_exp("mulh_m1",    22, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h0);
    run_exp("mulhu_max",  24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFE);
    run_exp("mul_m1",     21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h1);
    run_exp("div_zero",   25, 32'd7,         32'h0,         5'd0,  32'hFFFF_FFFF);
    run_exp("rem_zero",   27, 32'd7,         32'h0,         5'd0,  32'd7);
    run_exp("divu_zero",  26, 32'd9,         32'h0,         5'd0,  32'hFFFF_FFFF);
    run_exp("remu_zero",  28, 32'd9,         32'h0,         5'd0,  32'd9);
    run_exp("div_ovf",    25, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000);
    run_exp("rem_ovf",    27, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0);
    run_exp("rem_neg",    27, 32'hFFFF_FFF9, 32'd2,         5'd0,  32'hFFFF_FFFF);
    run_exp("div_neg",    25, 32'hFFFF_FFF9, 32'd2,         5'd0,  32'hFFFF_FFFD);
    run_exp("eq_same",    15, 32'h1234,      32'h1234,      5'd0,  32'h1);
    run_exp("geu_0_1",    20, 32'h0,         32'h1,         5'd0,  32'h0);
    run_exp("op40",       40, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3,  32'h0);
    run_exp("op29",       29, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3,  32'h0);

    // Back-to-back: each result must appear exactly one edge after its inputs.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (i > 0) check_eq("b2b_latency", result_o, exp_q.pop_front());
      op = int'($urandom_range(0, 28));
      a  = pick_operand();
      b  = pick_operand();
      sh = 5'($urandom());
      drive(op, a, b, sh);
      exp_q.push_back(ref_alu(op, a, b, sh));
    end
    @(negedge clk_i);
    check_eq("b2b_last", result_o, exp_q.pop_front());

    // Random ops across the full 6-bit opcode space.
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(29, 63))
                                       : int'($urandom_range(0, 28));
      a  = pick_operand();
      b  = pick_operand();
      sh = 5'($urandom());
      run_exp($sformatf("rand_op%0d", op), op, a, b, sh, ref_alu(op, a, b, sh));
    end

    // Mid-cycle reset clears the output without a clock edge.
    run_exp("pre_rst", 14, 32'hCAFE_F00D, 32'h0, 5'd0, 32'hCAFE_F00D);
    @(negedge clk_i);
    drive(14, 32'h1357_9BDF, 32'h0, 5'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("async_rst", result_o, 32'h0);
    @(posedge clk_i);
    #1;
    check_eq("rst_discard", result_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1, 32'd100, 32'd58, 5'd0);
    @(posedge clk_i);
    #1;
    check_eq("post_rst_sub", result_o, 32'd42);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
